// File: rtl/neuron_sequencer.sv
// Layer sequencer: steps one shared neuron datapath through NUM_NEURONS neurons
// (LOAD, 32 MAC steps, CAPTURE each). Optional abort input under NEURON_SEQ_ABORT_EN.
module neuron_sequencer #(
    parameter int NUM_NEURONS = 30,
    parameter int IDX_W       = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
`ifdef NEURON_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     busy,
    output logic [IDX_W-1:0]         neuron_idx,
    output logic [2:0]               counter_8,
    output logic [1:0]               counter_4,
    output logic                     second,
    input  logic [7:0]               neuron_out,
    output logic [NUM_NEURONS*8-1:0] layer_out,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, CAPTURE, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t state;
    logic   abort_hit;

    // busy && !out_valid is exactly LOAD, MAC or CAPTURE
`ifdef NEURON_SEQ_ABORT_EN
    assign abort_hit = abort && busy && !out_valid;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            neuron_idx <= '0;
            counter_8  <= '0;
            counter_4  <= '0;
            second     <= 1'b0;
            layer_out  <= '0;
        end else if (abort_hit) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            neuron_idx <= '0;
            counter_8  <= '0;
            counter_4  <= '0;
            second     <= 1'b0;
        end else begin
            second <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        neuron_idx <= '0;
                        layer_out  <= '0;
                    end
                end
                LOAD: begin
                    state     <= MAC;
                    counter_8 <= '0;
                    counter_4 <= '0;
                end
                MAC: begin
                    // second is registered, so raise it one step ahead of counter_4==3
                    counter_4 <= counter_4 + 2'd1;
                    second    <= (counter_4 == 2'd2);
                    if (counter_4 == 2'd3) begin
                        if (counter_8 == 3'd7) begin
                            state     <= CAPTURE;
                            counter_8 <= '0;
                        end else begin
                            counter_8 <= counter_8 + 3'd1;
                        end
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        if (neuron_idx == IDX_W'(i)) layer_out[8*i +: 8] <= neuron_out;
                    end
                    if (neuron_idx == LAST_IDX) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state      <= LOAD;
                        neuron_idx <= neuron_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        out_valid  <= 1'b0;
                        neuron_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomized bench for neuron_sequencer: cycle-count reference model plus a
// layer scoreboard popped whenever out_valid rises.
module tb_neuron_sequencer;

    localparam int N     = 3;
    localparam int IDX_W = 2;
    localparam int LW    = N * 8;
    localparam int PER   = 34;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             out_ready = 1'b0;
    logic             busy, second, out_valid;
    logic [IDX_W-1:0] neuron_idx;
    logic [2:0]       counter_8;
    logic [1:0]       counter_4;
    logic [7:0]       neuron_out;
    logic [LW-1:0]    layer_out;
    logic [7:0]       nv [4];

    always #5 clk = ~clk;

    assign neuron_out = nv[neuron_idx];

    neuron_sequencer #(.NUM_NEURONS(N), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef NEURON_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .neuron_idx (neuron_idx),
        .counter_8  (counter_8),
        .counter_4  (counter_4),
        .second     (second),
        .neuron_out (neuron_out),
        .layer_out  (layer_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
    typedef struct {logic [LW-1:0] lay; int st;} exp_t;

    mmode_t        m_mode = M_IDLE;
    int            m_t = 0;
    logic [LW-1:0] m_layer = '0;
    int            cyc = 0;
    int            st_cyc = 0;
    exp_t          sb [$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_layers = 0;
    logic          chk_en = 1'b0;
    logic          prev_v = 1'b0;

    function automatic logic [LW-1:0] upd(logic [LW-1:0] l, int i, logic [7:0] v);
        upd = l;
        upd[8*i +: 8] = v;
    endfunction

    function automatic exp_t mk(logic [LW-1:0] l, int s);
        mk.lay = l;
        mk.st  = s;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_t     <= 0;
            m_layer <= '0;
            sb.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode <= M_RUN; m_t <= 0; m_layer <= '0; st_cyc <= cyc;
                end
                M_RUN: if (abort) begin
                    m_mode <= M_IDLE; m_t <= 0;
                end else begin
                    if (m_t % PER == PER - 1) m_layer <= upd(m_layer, m_t / PER, nv[m_t / PER]);
                    if (m_t == PER * N - 1) begin
                        m_mode <= M_DONE;
                        sb.push_back(mk(upd(m_layer, N - 1, nv[N - 1]), st_cyc));
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                M_DONE: if (out_ready) m_mode <= M_IDLE;
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // expected {busy, out_valid, second, counter_8, counter_4}
    function automatic logic [7:0] exp_ctl(mmode_t md, int t);
        int  p;
        logic mac;
        p   = t % PER;
        mac = (md == M_RUN) && p >= 1 && p <= 32;
        exp_ctl = {md != M_IDLE, md == M_DONE,
                   mac && ((p - 1) % 4 == 3),
                   mac ? 3'((p - 1) / 4) : 3'd0,
                   mac ? 2'((p - 1) % 4) : 2'd0};
    endfunction

    function automatic logic [IDX_W-1:0] exp_idx(mmode_t md, int t);
        exp_idx = (md == M_RUN) ? IDX_W'(t / PER) : (md == M_DONE) ? IDX_W'(N - 1) : '0;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // per-cycle model check plus scoreboard monitor
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctl", {busy, out_valid, second, counter_8, counter_4}, exp_ctl(m_mode, m_t));
            chk("neuron_idx", neuron_idx, exp_idx(m_mode, m_t));
            chk("layer_out", layer_out, m_layer);
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL scoreboard @cyc %0d: out_valid with no expected layer", cyc);
                end else begin
                    chk("sb_layer", layer_out, sb[0].lay);
                    chk("sb_latency", 64'(cyc - sb[0].st - 1), 64'(PER * N));
                    void'(sb.pop_front());
                    n_layers++;
                end
            end
            prev_v <= out_valid;
        end
    end

    task automatic wait_model(mmode_t md, int tt, int lim, string nm);
        int k;
        k = 0;
        while (!(m_mode == md && (tt < 0 || m_t == tt)) && k < lim) begin
            @(negedge clk); k++;
        end
        if (k >= lim) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout %s: waited %0d cycles, required < %0d", nm, k, lim);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        int k;
        logic [LW-1:0] held;
        for (int i = 0; i < 4; i++) nv[i] = 8'h0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", out_valid, 1'b0);
        rst_n = 1'b1;

        // directed three-neuron layer
        for (int i = 0; i < N; i++) nv[i] = 8'h10 + 8'(i);
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 1;
        while (!out_valid && k < 200) begin @(negedge clk); k++; end
        chk("first_valid_cycle", 64'(k - 1), 64'd102);
        chk("directed_layer", layer_out, 24'h121110);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start     = ($urandom % 8) == 0;
            out_ready = ($urandom % 3) == 0;
            for (int i = 0; i < N; i++) nv[i] = 8'($urandom);
        end
        start = 1'b0; out_ready = 1'b1;
        wait_model(M_IDLE, -1, 200, "drain");

        // back-pressure: DONE held for 10 cycles, start pulses ignored
        out_ready = 1'b0;
        pulse_start();
        wait_model(M_DONE, -1, 200, "hold_done");
        @(negedge clk);
        held = layer_out;
        for (int c = 0; c < 10; c++) begin
            start = c[0];
            @(negedge clk);
            chk("hold_layer", layer_out, m_layer);
            chk("hold_valid", out_valid, 1'b1);
        end
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("transfer_busy", busy, 1'b0);
        chk("transfer_layer_kept", layer_out, held);

        // reset at MAC cycle 15 of neuron 1
        pulse_start();
        wait_model(M_RUN, PER + 1 + 15, 200, "mid_mac");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_reset_idx", neuron_idx, 2'd0);
        chk("mid_reset_layer", layer_out, '0);
        for (int i = 0; i < N; i++) nv[i] = 8'($urandom);
        pulse_start();
        wait_model(M_IDLE, -1, 200, "rebuild");

        // start held high: back-to-back layers
        k = n_layers;
        start = 1'b1;
        repeat (4 * (PER * N + 2)) @(negedge clk);
        start = 1'b0;
        wait_model(M_IDLE, -1, 200, "held_start");
        @(negedge clk);
        chk("held_start_layers", 64'(n_layers - k), 64'd4);

`ifdef NEURON_SEQ_ABORT_EN
        // abort during CAPTURE of neuron 0
        k = n_layers;
        pulse_start();
        wait_model(M_RUN, PER - 1, 100, "abort_capture");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        repeat (150) @(negedge clk);
        chk("abort_no_valid", 64'(n_layers - k), 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
